// File: rtl/piso_reader_if.sv
// Handshake/data bundle for piso_reader: parallel word in, serial bit stream out.
interface piso_reader_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in;
   logic             load;
   logic             stall;
   logic             ready;
   logic             sout;
   logic             sout_valid;
   logic             done;

   modport master (
      output in, load, stall,
      input  ready, sout, sout_valid, done
   );

   modport slave (
      input  in, load, stall,
      output ready, sout, sout_valid, done
   );
endinterface

// File: rtl/piso_reader.sv
// Parallel-in serial-out reader: captures a WIDTH-bit word on load and
// shifts it out one bit per unstalled cycle, then pulses done for one cycle.
module piso_reader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic          clk,
   input  logic          clear,
   piso_reader_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic ready, sout, sout_valid, done;

   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every signal driven below gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      ready      = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (bus.load) begin
               shreg_d = bus.in;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            sout = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            // A stalled cycle keeps everything, so sout repeats the same bit.
            if (!bus.stall) begin
               sout_valid = 1'b1;
               shreg_d    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg_q[WIDTH-1:1]};
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.ready      = ready;
   assign bus.sout       = sout;
   assign bus.sout_valid = sout_valid;
   assign bus.done       = done;
endmodule

// File: tb/tb_piso_reader.sv
// Bench for piso_reader: LSB-first and MSB-first instances share one stimulus
// and are compared every cycle against a word/bit-index model.
module tb_piso_reader;
   localparam int W = 8;

   logic         clk;
   logic         clear;
   logic [W-1:0] in_s;
   logic         load_s;
   logic         stall_s;

   piso_reader_if #(.WIDTH(W)) if0 ();
   piso_reader_if #(.WIDTH(W)) if1 ();

   assign if0.in = in_s;  assign if0.load = load_s;  assign if0.stall = stall_s;
   assign if1.in = in_s;  assign if1.load = load_s;  assign if1.stall = stall_s;

   piso_reader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .clear(clear), .bus(if0));
   piso_reader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .clear(clear), .bus(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: -1 = idle, 0..W-1 = index of the bit currently presented, W = done.
   int           m_phase = -1;
   logic [W-1:0] m_word  = '0;

   always @(posedge clk or posedge clear) begin
      if (clear) begin
         m_phase <= -1;
      end else if (m_phase == -1) begin
         if (load_s) begin
            m_word  <= in_s;
            m_phase <= 0;
         end
      end else if (m_phase < W) begin
         if (!stall_s) m_phase <= m_phase + 1;
      end else begin
         m_phase <= -1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit q0[$];
   bit q1[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int done_q[$];
   int gap_cnt  = 0;

   always @(negedge clk) begin
      logic in_shift;
      logic e_s0, e_s1;
      in_shift = (m_phase >= 0) && (m_phase < W);
      e_s0 = in_shift ? m_word[m_phase] : 1'b0;
      e_s1 = in_shift ? m_word[W-1-m_phase] : 1'b0;
      check("ready_lsb", 32'(if0.ready),      32'(m_phase == -1));
      check("ready_msb", 32'(if1.ready),      32'(m_phase == -1));
      check("valid_lsb", 32'(if0.sout_valid), 32'(in_shift && !stall_s));
      check("valid_msb", 32'(if1.sout_valid), 32'(in_shift && !stall_s));
      check("done_lsb",  32'(if0.done),       32'(m_phase == W));
      check("done_msb",  32'(if1.done),       32'(m_phase == W));
      check("sout_lsb",  32'(if0.sout),       32'(e_s0));
      check("sout_msb",  32'(if1.sout),       32'(e_s1));

      if (if0.sout_valid) q0.push_back(if0.sout);
      if (if1.sout_valid) q1.push_back(if1.sout);
      if (if0.done) begin
         done_cnt++;
         done_cyc = cyc;
         done_q.push_back(cyc);
      end
      if (!if0.ready && !if0.done && !if0.sout_valid) gap_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      q0.delete();
      q1.delete();
      done_q.delete();
      done_cnt = 0;
      gap_cnt  = 0;
   endtask

   function automatic logic [W-1:0] lsb_word(input int base);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) if (base + i < q0.size()) w[i] = q0[base+i];
      return w;
   endfunction

   function automatic logic [W-1:0] msb_word(input int base);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++) if (base + i < q1.size()) w[W-1-i] = q1[base+i];
      return w;
   endfunction

   int ld;

   initial begin
      clear = 1'b1;  in_s = '0;  load_s = 1'b0;  stall_s = 1'b0;
      tick(2);
      check("rst_ready", 32'(if0.ready), 32'd1);
      check("rst_valid", 32'(if0.sout_valid), 32'd0);
      check("rst_done",  32'(if0.done), 32'd0);
      check("rst_sout",  32'(if0.sout), 32'd0);
      // load while clear is held must be ignored
      in_s = 8'hC3;  load_s = 1'b1;
      tick(2);
      check("clear_dominates_load", 32'(if0.ready), 32'd1);
      load_s = 1'b0;  clear = 1'b0;
      tick(1);

      // A5, no stalls; in changes right after capture
      clear_logs();
      in_s = 8'hA5;  load_s = 1'b1;
      tick(1);  ld = cyc;
      load_s = 1'b0;  in_s = 8'h5A;
      tick(10);
      check("a5_nbits",    32'(q0.size()), 32'd8);
      check("a5_lsb_word", 32'(lsb_word(0)), 32'hA5);
      check("a5_msb_word", 32'(msb_word(0)), 32'hA5);
      check("a5_done_cnt", 32'(done_cnt), 32'd1);
      check("a5_done_lat", 32'(done_cyc - ld), 32'd8);
      check("a5_ready",    32'(if0.ready), 32'd1);

      // 3C with a 3-cycle stall after the 2nd bit
      clear_logs();
      in_s = 8'h3C;  load_s = 1'b1;
      tick(1);  ld = cyc;
      load_s = 1'b0;
      tick(2);
      stall_s = 1'b1;
      tick(3);
      stall_s = 1'b0;
      tick(12);
      check("3c_lsb_word", 32'(lsb_word(0)), 32'h3C);
      check("3c_msb_word", 32'(msb_word(0)), 32'h3C);
      check("3c_gap",      32'(gap_cnt), 32'd3);
      check("3c_done_lat", 32'(done_cyc - ld), 32'd11);

      // FF with a second load attempted mid-word
      clear_logs();
      in_s = 8'hFF;  load_s = 1'b1;
      tick(1);
      load_s = 1'b0;
      tick(2);
      in_s = 8'h00;  load_s = 1'b1;
      tick(3);
      load_s = 1'b0;
      tick(8);
      check("ff_nbits",    32'(q0.size()), 32'd8);
      check("ff_lsb_word", 32'(lsb_word(0)), 32'hFF);
      check("ff_msb_word", 32'(msb_word(0)), 32'hFF);
      check("ff_done_cnt", 32'(done_cnt), 32'd1);

      // A5 aborted by an asynchronous clear between edges 3 and 4
      clear_logs();
      in_s = 8'hA5;  load_s = 1'b1;
      tick(1);
      load_s = 1'b0;
      tick(3);
      #2 clear = 1'b1;
      #1;
      check("abort_ready", 32'(if0.ready), 32'd1);
      check("abort_valid", 32'(if0.sout_valid), 32'd0);
      check("abort_sout",  32'(if1.sout), 32'd0);
      check("abort_done",  32'(if0.done), 32'd0);
      in_s = 8'h01;  load_s = 1'b1;
      tick(2);
      clear = 1'b0;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      clear_logs();
      tick(1);  ld = cyc;
      load_s = 1'b0;
      tick(10);
      check("01_lsb_word", 32'(lsb_word(0)), 32'h01);
      check("01_msb_word", 32'(msb_word(0)), 32'h01);
      check("01_done_lat", 32'(done_cyc - ld), 32'd8);

      // load held high: one word per W+2 cycles
      clear_logs();
      in_s = 8'h81;  load_s = 1'b1;
      tick(1);  ld = cyc;
      tick(39);
      load_s = 1'b0;
      tick(12);
      check("b2b_done_cnt", 32'(done_cnt), 32'd4);
      check("b2b_nbits",    32'(q0.size()), 32'd32);
      check("b2b_word0",    32'(lsb_word(0)), 32'h81);
      check("b2b_word3",    32'(msb_word(24)), 32'h81);
      if (done_q.size() == 4) begin
         check("b2b_first_lat", 32'(done_q[0] - ld), 32'd8);
         for (int i = 1; i < 4; i++)
            check("b2b_period", 32'(done_q[i] - done_q[i-1]), 32'd10);
      end else begin
         check("b2b_done_q_size", 32'(done_q.size()), 32'd4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/piso_reader.md
PISO_READER -- requirements
Module: piso_reader

Interface
REQ-001 Parameter: WIDTH, 8, width of the parallel word read out; legal values 2..32.
REQ-002 Parameter: MSB_FIRST, 0, 0 = shift out LSB first, 1 = shift out MSB first.
REQ-003 Port: clk  input  1  single clock; all state updates on the posedge.
REQ-004 Port: clear  input  1  reset; asynchronous and active-high.
REQ-005 Port: in  input  WIDTH  parallel word to be serialized.
REQ-006 Port: load  input  1  capture request; honoured only while ready=1.
REQ-007 Port: stall  input  1  freezes shifting while in SHIFT.
REQ-008 Port: ready  output  1  block is idle and will accept load.
REQ-009 Port: sout  output  1  current serial bit.
REQ-010 Port: sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 Port: done  output  1  single-cycle pulse after the last bit.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE: ready=1, sout_valid=0, done=0, sout=0.
REQ-014 IDLE with load=1 at a posedge SHALL capture in into the shift register, set the bit counter to 0, and enter SHIFT.
REQ-015 IDLE with load=0 SHALL hold all state.
REQ-016 In SHIFT: ready=0; sout = shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
REQ-017 In SHIFT with stall=0: sout_valid=1; at the posedge, shift one position toward the output end (zero fill) and increment the counter.
REQ-018 In SHIFT with stall=1: sout_valid=0; shift register, counter and state SHALL hold; sout SHALL keep its value.
REQ-019 The transition SHIFT->DONE SHALL occur at the posedge where the counter equals WIDTH-1 and stall=0, i.e. after exactly WIDTH unstalled cycles.
REQ-020 In DONE: done=1, ready=0, sout_valid=0, sout=0; next posedge unconditionally returns to IDLE.
REQ-021 load SHALL be ignored in SHIFT and DONE; a word presented then is not captured and never lost-state-corrupting.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within a word.
REQ-023 Latency: load sampled at edge k with no stalls -> first valid bit in cycle after edge k, last in cycle after edge k+WIDTH-1, done in cycle after edge k+WIDTH, ready in cycle after edge k+WIDTH+1.
REQ-024 Back-to-back words: load held high SHALL be accepted at the first edge in IDLE, giving one word per WIDTH+2 cycles.
REQ-025 in SHALL be sampled only at the accepting edge; later changes to in SHALL NOT affect the word in flight.

Reset
REQ-026 clear=1 SHALL immediately (without a clock edge) force state=IDLE, shift register=0, counter=0.
REQ-027 During and after clear: ready=1, sout=0, sout_valid=0, done=0.
REQ-028 clear asserted mid-SHIFT SHALL abort the word with no done pulse.
REQ-029 clear SHALL dominate load at the same edge; nothing is captured while clear=1.
REQ-030 The first load honoured SHALL be at the first posedge after clear deasserts.

Verification (WIDTH=8)
REQ-031 MSB_FIRST=0, load in=8'hA5 at edge 0, stall=0 -> sout 1,0,1,0,0,1,0,1 with sout_valid=1 after edges 0..7; done=1 after edge 8; ready=1 after edge 9.
REQ-032 MSB_FIRST=1, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 reversed order (MSB first: 1,0,1,0,0,1,0,1 read from bit 7 down), checked bitwise against in[7..0].
REQ-033 Load 8'h3C, stall=1 for 3 cycles after the 2nd bit -> sout_valid low 3 cycles, sout held, full sequence 0,0,1,1,1,1,0,0 intact; done 3 cycles later than REQ-031.
REQ-034 Load 8'hFF, assert load again with in=8'h00 during SHIFT -> second word ignored, output stays all ones, single done pulse.
REQ-035 Load 8'hA5, assert clear asynchronously between edges 3 and 4 -> outputs drop immediately (ready=1, sout_valid=0), no done pulse; new load 8'h01 after release serializes correctly.
REQ-036 load held high continuously with in=8'h81 -> words start every 10 cycles, done pulses every 10 cycles.
